led_panel_bcm: RTL and testbench
================================

# led_panel_bcm

Parametrised HUB-style RGB LED panel scan driver with binary-code-modulation (BCM) brightness and a double-buffered frame store. Drives dual-half panels (upper and lower half shifted in parallel) with a direct binary row address. A host-side write port fills the back buffer. A swap request exchanges buffers only at a frame boundary, so the display never tears.

## Interface
Parameters:
- COLS, 32: columns per row (power of two, ≥2)
- ROW_BITS, 2: row address width; each half has 2^ROW_BITS rows
- DEPTH, 2: bits per colour channel (bit planes)
- BASE_TICKS, 4: unblanked cycles for plane 0 (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe into back buffer
- wr_addr  in  1+ROW_BITS+log2(COLS)  {half, row, col}; half=0 is upper
- wr_data  in  3*DEPTH  {r[DEPTH-1:0], g, b}
- swap_req  in  1  one-cycle pulse; request buffer exchange
- swap_ack  out  1  one-cycle pulse when exchange happens
- frame_end  out  1  one-cycle pulse at end of each full frame
- r0, g0, b0  out  1 each  upper-half serial data
- r1, g1, b1  out  1 each  lower-half serial data
- sclk  out  1  shift clock; panel samples on rising edge
- latch  out  1  active-high latch
- blank  out  1  active-high output blank
- row_addr  out  ROW_BITS  displayed row

## Operation
- Storage: two banks of 2·2^ROW_BITS·COLS pixels × 3·DEPTH bits. `front` selects the displayed bank; writes go to bank `!front`.
- Storage is not cleared by reset. `front` resets to 0.
- Pixel output for plane p: colour bit = channel[p].
- Internal counters: col (log2 COLS), row (ROW_BITS), plane (log2 DEPTH, min 1), show counter (wide enough for BASE_TICKS<<(DEPTH-1)).
- State machine:
  - SHIFT_LO: sclk=0. Drive r0..b1 for front[{0,row,col}] and front[{1,row,col}] at the current plane. Next state: SHIFT_HI.
  - SHIFT_HI: sclk=1, data held. If col==COLS-1, set col=0 and go to LATCH. Otherwise col+1 and go to SHIFT_LO.
  - LATCH: sclk=0, blank=1, latch=1, row_addr<=row. Load show counter with BASE_TICKS<<plane. Next state: SHOW.
  - SHOW: latch=0, blank=0. Decrement the counter. At count 1, go to NEXT.
  - NEXT: blank=1. If plane<DEPTH-1, plane+1. Otherwise plane=0 and row+1, wrapping at 2^ROW_BITS. Next state: SHIFT_LO.
- Frame end: the NEXT cycle with plane==DEPTH-1 and row==all-ones.
  - frame_end is asserted that cycle.
  - If a swap is pending (or swap_req arrives that cycle), toggle `front`, clear pending, and pulse swap_ack.
- swap_req at any other time sets `pending`. Repeated requests before a frame end collapse into one.
- A write in the swap cycle targets the pre-toggle back bank.
- wr_en is always accepted with no backpressure. Writes never affect the displayed bank.

## Timing
- All outputs are registered.
- Reset values: sclk=0, latch=0, blank=1, r/g/b=0, row_addr=0, swap_ack=0, frame_end=0. Internally: state=SHIFT_LO, col=row=plane=0, pending=0, front=0.
- First sclk rising edge occurs 2 cycles after reset deasserts. Data is stable one cycle before and during each sclk high.
- Per row-plane cost: 2·COLS + 1 + (BASE_TICKS<<p) + 1 cycles. blank is low for exactly BASE_TICKS<<p cycles.
- row_addr changes only in LATCH, while blank=1.
- Frame period: 2^ROW_BITS · Σ_p (2·COLS + 2 + (BASE_TICKS<<p)).
- Write latency: data is visible on the display from the first SHIFT_LO after the swap that exposes it.
- Reset mid-operation: returns to reset values on the next edge. Any pending swap is dropped.

## Test plan
Bench parameters: COLS=4, ROW_BITS=1, DEPTH=2, BASE_TICKS=2.
- Reset: hold reset 3 cycles → blank=1, sclk=0, latch=0, row_addr=0, all rgb=0. 2 cycles after release, the first sclk rise occurs with 4 sclk rises before the first latch pulse.
- Plane timing: run free → blank low for 2 cycles (plane 0), then 4 cycles (plane 1). Each row-plane period is 12 and 14 cycles; frame_end pulses every 52 cycles.
- Write + swap: write {half0,row0,col2} r=2'b01, g=2'b10, b=0. Pulse swap_req mid-frame → swap_ack coincides with the next frame_end.
  - Next frame row0: r0=1 at col2 sclk rise in plane 0 only; g0=1 at col2 sclk rise in plane 1 only. All other bits are 0.
- Tear-free: write the back bank continuously without swap_req → outputs never change; swap_ack stays 0.
- Simultaneous: swap_req on the frame_end cycle → swap_ack the same cycle. Two swap_req pulses in one frame → exactly one swap_ack.
- Reset mid-SHOW: assert reset while blank=0 → next cycle blank=1, row_addr=0, pending cleared (no swap_ack at the following frame_end).

Source files
------------

// File: rtl/led_panel_bcm.sv
// led_panel_bcm: HUB-style dual-half RGB panel scan driver with binary-code-modulation
// brightness and a double-buffered frame store that swaps only at frame boundaries.
module led_panel_bcm #(
  parameter int COLS       = 32,
  parameter int ROW_BITS   = 2,
  parameter int DEPTH      = 2,
  parameter int BASE_TICKS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ROW_BITS+$clog2(COLS):0] wr_addr,
  input  logic [3*DEPTH-1:0]             wr_data,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           frame_end,
  output logic                           r0,
  output logic                           g0,
  output logic                           b0,
  output logic                           r1,
  output logic                           g1,
  output logic                           b1,
  output logic                           sclk,
  output logic                           latch,
  output logic                           blank,
  output logic [ROW_BITS-1:0]            row_addr
);

  localparam int CW = $clog2(COLS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = 1 + ROW_BITS + CW;
  localparam int DW = 3 * DEPTH;
  localparam int SW = $clog2((BASE_TICKS << (DEPTH - 1)) + 1);

  typedef enum logic [2:0] {
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_SHOW,
    S_NEXT
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       col, col_nxt;
  logic [ROW_BITS-1:0] row, row_nxt;
  logic [PW-1:0]       plane, plane_nxt;
  logic [SW-1:0]       cnt, cnt_nxt;
  logic                pending, pending_nxt;
  logic                front, front_nxt;

  logic                sclk_nxt, latch_nxt, blank_nxt, frame_end_nxt, swap_ack_nxt;
  logic [5:0]          rgb_nxt;
  logic [ROW_BITS-1:0] row_addr_nxt;

  logic [DW-1:0]       mem [2][2**AW];
  logic [AW-1:0]       addr_top, addr_bot;
  logic [DW-1:0]       pix_top, pix_bot;
  logic [DEPTH-1:0]    r_top, g_top, b_top, r_bot, g_bot, b_bot;

  // Host writes always land in the bank not being displayed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[~front][wr_addr] <= wr_data;
  end

  assign addr_top = {1'b0, row, col};
  assign addr_bot = {1'b1, row, col};
  assign pix_top  = mem[front][addr_top];
  assign pix_bot  = mem[front][addr_bot];
  assign {r_top, g_top, b_top} = pix_top;
  assign {r_bot, g_bot, b_bot} = pix_bot;

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    plane_nxt     = plane;
    cnt_nxt       = cnt;
    pending_nxt   = pending | swap_req;
    front_nxt     = front;
    sclk_nxt      = 1'b0;
    latch_nxt     = 1'b0;
    blank_nxt     = 1'b1;
    rgb_nxt       = {r0, g0, b0, r1, g1, b1};
    row_addr_nxt  = row_addr;
    frame_end_nxt = 1'b0;
    swap_ack_nxt  = 1'b0;
    unique case (state)
      S_SHIFT_LO: begin
        rgb_nxt   = {r_top[plane], g_top[plane], b_top[plane],
                     r_bot[plane], g_bot[plane], b_bot[plane]};
        state_nxt = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        sclk_nxt = 1'b1;
        if (col == CW'(COLS - 1)) begin
          col_nxt   = '0;
          state_nxt = S_LATCH;
        end else begin
          col_nxt   = col + 1'b1;
          state_nxt = S_SHIFT_LO;
        end
      end
      S_LATCH: begin
        latch_nxt    = 1'b1;
        row_addr_nxt = row;
        cnt_nxt      = SW'(BASE_TICKS) << plane;
        state_nxt    = S_SHOW;
      end
      S_SHOW: begin
        blank_nxt = 1'b0;
        cnt_nxt   = cnt - 1'b1;
        if (cnt == SW'(1)) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        state_nxt = S_SHIFT_LO;
        if (plane != PW'(DEPTH - 1)) begin
          plane_nxt = plane + 1'b1;
        end else begin
          plane_nxt = '0;
          row_nxt   = row + 1'b1;
          // Last plane of the last row: the only point where the banks may exchange.
          if (&row) begin
            frame_end_nxt = 1'b1;
            if (pending | swap_req) begin
              front_nxt    = ~front;
              pending_nxt  = 1'b0;
              swap_ack_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = S_SHIFT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= S_SHIFT_LO;
      col                      <= '0;
      row                      <= '0;
      plane                    <= '0;
      cnt                      <= '0;
      pending                  <= 1'b0;
      front                    <= 1'b0;
      sclk                     <= 1'b0;
      latch                    <= 1'b0;
      blank                    <= 1'b1;
      {r0, g0, b0, r1, g1, b1} <= '0;
      row_addr                 <= '0;
      swap_ack                 <= 1'b0;
      frame_end                <= 1'b0;
    end else begin
      state                    <= state_nxt;
      col                      <= col_nxt;
      row                      <= row_nxt;
      plane                    <= plane_nxt;
      cnt                      <= cnt_nxt;
      pending                  <= pending_nxt;
      front                    <= front_nxt;
      sclk                     <= sclk_nxt;
      latch                    <= latch_nxt;
      blank                    <= blank_nxt;
      {r0, g0, b0, r1, g1, b1} <= rgb_nxt;
      row_addr                 <= row_addr_nxt;
      swap_ack                 <= swap_ack_nxt;
      frame_end                <= frame_end_nxt;
    end
  end

endmodule

// File: tb/tb_led_panel_bcm.sv
// Bench for led_panel_bcm: per-cycle scoreboard against a frame-position model,
// table-driven pixel vectors, and directed swap / reset sequences.
module tb_led_panel_bcm;

  localparam int COLS       = 4;
  localparam int ROW_BITS   = 1;
  localparam int DEPTH      = 2;
  localparam int BASE_TICKS = 2;
  localparam int FRAME      = 52;

  logic       clk;
  logic       reset, wr_en, swap_req;
  logic [3:0] wr_addr;
  logic [5:0] wr_data;
  logic       swap_ack, frame_end, r0, g0, b0, r1, g1, b1, sclk, latch, blank;
  logic [0:0] row_addr;

  led_panel_bcm #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_TICKS(BASE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_end(frame_end),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .sclk(sclk), .latch(latch), .blank(blank), .row_addr(row_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] outs;
    bit          rgb_known;
    bit          cap;
    int          row;
    int          plane;
    int          col;
  } exp_t;

  typedef struct {
    bit         half;
    bit         row;
    logic [1:0] col;
    logic [5:0] data;
    logic [5:0] exp0;
    logic [5:0] exp1;
  } vec_t;

  exp_t       sbq[$];
  vec_t       vecs[6];
  int         n_checks, n_pass;

  int         k, cyc;
  bit         m_front, m_pending, data_known;
  logic [5:0] m_mem [2][16];
  logic [5:0] m_rgb;
  logic       m_row_addr;
  logic [5:0] cap [2][2][4];

  int         rel, first_sclk, rises, nlat, nrun, nfe, run, acks;
  int         lat_at[3];
  int         runs[2];
  int         fe_at[2];
  bit         seen_latch, prev_sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic step();
    exp_t       e;
    int         p, s, o, n, srow, spl, a;
    logic [5:0] top, bot;
    logic [11:0] act, mask;
    bit         fe, ack, sclk_e, latch_e, blank_e;
    e.row = 0; e.plane = 0; e.col = 0; e.cap = 0;
    e.rgb_known = reset ? 1'b1 : data_known;
    if (reset) begin
      k = 0; m_pending = 0; m_front = 0; m_rgb = '0; m_row_addr = 1'b0;
      e.outs = {6'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      p = k % FRAME;
      o = p; s = 0;
      while (o >= 2*COLS + 2 + (BASE_TICKS << (s % DEPTH))) begin
        o -= 2*COLS + 2 + (BASE_TICKS << (s % DEPTH));
        s++;
      end
      srow = s / DEPTH; spl = s % DEPTH; n = BASE_TICKS << spl;
      if (o == 2*COLS) m_row_addr = srow[0];
      if (o < 2*COLS && o % 2 == 0) begin
        a   = srow*COLS + o/2;
        top = m_mem[m_front][a];
        bot = m_mem[m_front][a + (1 << ROW_BITS)*COLS];
        m_rgb = {top[4+spl], top[2+spl], top[spl], bot[4+spl], bot[2+spl], bot[spl]};
      end
      sclk_e  = (o < 2*COLS) && (o % 2 == 1);
      latch_e = (o == 2*COLS);
      blank_e = !(o > 2*COLS && o <= 2*COLS + n);
      e.cap = sclk_e; e.row = srow; e.plane = spl; e.col = o / 2;
      fe = (p == FRAME - 1); ack = 1'b0;
      if (wr_en) m_mem[!m_front][wr_addr] = wr_data;
      if (fe) begin
        if (m_pending || swap_req) begin
          m_front = !m_front; m_pending = 0; ack = 1'b1;
        end
      end else if (swap_req) m_pending = 1;
      e.outs = {m_rgb, sclk_e, latch_e, blank_e, m_row_addr, fe, ack};
      k++;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    e    = sbq.pop_front();
    act  = {r0, g0, b0, r1, g1, b1, sclk, latch, blank, row_addr, frame_end, swap_ack};
    mask = e.rgb_known ? 12'hFFF : 12'h03F;
    check($sformatf("cycle %0d outputs", cyc), 32'(act & mask), 32'(e.outs & mask));
    if (e.cap) cap[e.row][e.plane][e.col] = act[11:6];
    if (reset) rel = 0;
    else begin
      rel++;
      if (sclk && first_sclk < 0) first_sclk = rel;
      if (!seen_latch && sclk && !prev_sclk) rises++;
      if (latch) begin
        if (nlat < 3) lat_at[nlat] = rel;
        nlat++; seen_latch = 1;
      end
      if (!blank) run++;
      else begin
        if (run > 0 && nrun < 2) begin runs[nrun] = run; nrun++; end
        run = 0;
      end
      if (frame_end && nfe < 2) begin fe_at[nfe] = rel; nfe++; end
      if (swap_ack) acks++;
    end
    prev_sclk = sclk;
    cyc++;
  endtask

  task automatic advance_to(input int target);
    for (int i = 0; i < FRAME && (k % FRAME) != target; i++) step();
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1; step(); swap_req = 1'b0;
  endtask

  task automatic swap_and_wait(input string name);
    bit got;
    pulse_swap();
    got = swap_ack;
    for (int i = 0; i < 2*FRAME + 10 && !got; i++) begin
      step(); got = swap_ack;
    end
    check({name, " swap_ack seen"}, 32'(got), 32'd1);
    if (got) check({name, " swap_ack with frame_end"}, 32'(frame_end), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, others;
    vecs[0] = '{1'b0, 1'b0, 2'd2, 6'b01_10_00, 6'b100_000, 6'b010_000};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 6'b11_00_01, 6'b000_101, 6'b000_100};
    vecs[2] = '{1'b0, 1'b1, 2'd3, 6'b00_11_10, 6'b010_000, 6'b011_000};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 6'b10_01_11, 6'b000_011, 6'b000_101};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 6'b11_11_11, 6'b111_000, 6'b111_000};
    vecs[5] = '{1'b1, 1'b1, 2'd3, 6'b01_01_01, 6'b000_111, 6'b000_000};
    for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) m_mem[b][i] = '0;
    n_checks = 0; n_pass = 0; cyc = 0; k = 0;
    first_sclk = -1; rises = 0; nlat = 0; nrun = 0; nfe = 0; run = 0; acks = 0;
    seen_latch = 0; prev_sclk = 0; data_known = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;

    repeat (3) step();
    check("reset blank", 32'(blank), 32'd1);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset latch", 32'(latch), 32'd0);
    check("reset row_addr", 32'(row_addr), 32'd0);
    check("reset rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'd0);
    reset = 1'b0;

    repeat (2*FRAME + 4) step();
    check("first sclk rise cycle", first_sclk, 2);
    check("sclk rises before first latch", rises, 4);
    check("plane0 blank-low length", runs[0], 2);
    check("plane1 blank-low length", runs[1], 4);
    check("plane0 row-plane period", lat_at[1] - lat_at[0], 12);
    check("plane1 row-plane period", lat_at[2] - lat_at[1], 14);
    check("first frame_end cycle", fe_at[0], 52);
    check("frame_end period", fe_at[1] - fe_at[0], 52);

    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = '0; step();
    end
    wr_en = 1'b0;
    swap_and_wait("init");
    data_known = 1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = '0; step();
    end
    wr_en = 1'b0;

    for (int v = 0; v < 6; v++) begin
      wr_en = 1'b1; wr_addr = {vecs[v].half, vecs[v].row, vecs[v].col};
      wr_data = vecs[v].data; step(); wr_en = 1'b0;
      advance_to(20);
      swap_and_wait($sformatf("vec%0d", v));
      for (int r = 0; r < 2; r++) for (int pl = 0; pl < 2; pl++)
        for (int c = 0; c < 4; c++) cap[r][pl][c] = 6'h3F;
      repeat (FRAME) step();
      check($sformatf("vec%0d plane0 bits", v),
            32'(cap[vecs[v].row][0][vecs[v].col]), 32'(vecs[v].exp0));
      check($sformatf("vec%0d plane1 bits", v),
            32'(cap[vecs[v].row][1][vecs[v].col]), 32'(vecs[v].exp1));
      others = 0;
      for (int r = 0; r < 2; r++) for (int pl = 0; pl < 2; pl++)
        for (int c = 0; c < 4; c++)
          if (!(r == int'(vecs[v].row) && c == int'(vecs[v].col)) && cap[r][pl][c] != 0)
            others++;
      check($sformatf("vec%0d other pixels zero", v), others, 0);
      swap_and_wait($sformatf("vec%0d restore", v));
      wr_en = 1'b1; wr_addr = {vecs[v].half, vecs[v].row, vecs[v].col};
      wr_data = '0; step(); wr_en = 1'b0;
    end

    a0 = acks;
    for (int i = 0; i < FRAME + 8; i++) begin
      wr_en = 1'b1; wr_addr = 4'($urandom_range(15, 0)); wr_data = 6'($urandom_range(63, 0));
      step();
    end
    wr_en = 1'b0;
    check("tear-free no swap_ack", acks - a0, 0);

    advance_to(FRAME - 1);
    pulse_swap();
    check("simultaneous swap_ack", 32'(swap_ack), 32'd1);
    check("simultaneous frame_end", 32'(frame_end), 32'd1);

    advance_to(10);
    pulse_swap();
    advance_to(30);
    pulse_swap();
    a0 = acks;
    repeat (100) step();
    check("double request single swap_ack", acks - a0, 1);

    advance_to(20);
    pulse_swap();
    advance_to(36);
    check("pre-reset blank low", 32'(blank), 32'd0);
    check("pre-reset row_addr", 32'(row_addr), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid-show reset blank", 32'(blank), 32'd1);
    check("mid-show reset row_addr", 32'(row_addr), 32'd0);
    a0 = acks;
    repeat (110) step();
    check("pending dropped by reset", acks - a0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
